// File: rtl/posit_decode_seq.sv
// -----------------------------------------------------------------------------
// posit_decode_seq
//   Multi-cycle posit field decoder. One N-bit posit is accepted per start and
//   its regime run is scanned serially. The decoder returns the sign, zero and
//   NaR flags, a signed combined scale (k*2^ES + e) and an MSB-aligned
//   fraction with the hidden bit removed.
//
// Ports
//   clk_i    in   1        clock, rising edge
//   rst_i    in   1        asynchronous active-high reset
//   start_i  in   1        request, sampled only while busy_o = 0
//   in_i     in   N        posit operand, sampled on the accepting edge
//   busy_o   out  1        high from the accepting edge until done_o rises
//   done_o   out  1        one-cycle pulse, results valid from this cycle
//   sign_o   out  1        sign bit of the accepted operand
//   zero_o   out  1        operand was zero
//   inf_o    out  1        operand was NaR (1 followed by zeros)
//   scale_o  out  ES+BS+1  two's complement k*2^ES + e
//   frac_o   out  N-ES     fraction, MSB-aligned, zero-padded
//
// Build option
//   POSIT_DEC_FAST_SCAN_EN : scan two regime bits per edge. Output values are
//   unchanged; only the scan latency shrinks.
//
// States
//   S_IDLE | waiting for start
//   S_SCAN | counting the regime run
//   S_SPEC | zero / NaR operand, results written on the exit edge
//   S_DONE | scan finished, results written on the exit edge
// -----------------------------------------------------------------------------
module posit_decode_seq #(
  parameter int N  = 16,
  parameter int ES = 2,
  parameter int BS = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [N-1:0]     in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             sign_o,
  output logic             zero_o,
  output logic             inf_o,
  output logic [ES+BS:0]   scale_o,
  output logic [N-ES-1:0]  frac_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_SPEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [N-1:0]  ONE_N = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  NAR_N = {1'b1, {(N-1){1'b0}}};
  localparam logic [BS-1:0] R_ONE = {{(BS-1){1'b0}}, 1'b1};
  localparam logic [BS-1:0] R_MAX = BS'(N-1);
  localparam logic [BS:0]   K_ONE = {{BS{1'b0}}, 1'b1};
  localparam logic [BS:0]   K_ZRO = '0;

  state_t state_q, state_d;

  // Bits following the sign, MSB-aligned; consumed bits shift out the top.
  logic [N-2:0]    sh_q, sh_d;
  logic [BS-1:0]   r_q, r_d;
  logic            rc_q, rc_d;
  logic            sgn_q, sgn_d;
  logic            isz_q, isz_d;

  logic            done_q, done_d;
  logic            sign_q, sign_d;
  logic            zero_q, zero_d;
  logic            inf_q, inf_d;
  logic [ES+BS:0]  scale_q, scale_d;
  logic [N-ES-1:0] frac_q, frac_d;

  logic [N-1:0]    mag;
  logic [BS:0]     k_w;

`ifdef POSIT_DEC_FAST_SCAN_EN
  logic [N-2:0]    sh_t;
  logic [BS-1:0]   r_t;
  logic            fin_t;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      r_q     <= '0;
      rc_q    <= 1'b0;
      sgn_q   <= 1'b0;
      isz_q   <= 1'b0;
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      inf_q   <= 1'b0;
      scale_q <= '0;
      frac_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      r_q     <= r_d;
      rc_q    <= rc_d;
      sgn_q   <= sgn_d;
      isz_q   <= isz_d;
      done_q  <= done_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      inf_q   <= inf_d;
      scale_q <= scale_d;
      frac_q  <= frac_d;
    end
  end

  // Negative operands are decoded from their two's complement magnitude.
  assign mag = in_i[N-1] ? (~in_i + ONE_N) : in_i;

  // k = r-1 for a run of ones, -r for a run of zeros.
  assign k_w = rc_q ? ({1'b0, r_q} - K_ONE) : (K_ZRO - {1'b0, r_q});

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    r_d     = r_q;
    rc_d    = rc_q;
    sgn_d   = sgn_q;
    isz_d   = isz_q;
    done_d  = 1'b0;
    sign_d  = sign_q;
    zero_d  = zero_q;
    inf_d   = inf_q;
    scale_d = scale_q;
    frac_d  = frac_q;
`ifdef POSIT_DEC_FAST_SCAN_EN
    sh_t    = sh_q;
    r_t     = r_q;
    fin_t   = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sgn_d = in_i[N-1];
          isz_d = (in_i == '0);
          sh_d  = mag[N-2:0];
          rc_d  = mag[N-2];
          r_d   = '0;
          if ((in_i == '0) || (in_i == NAR_N)) begin
            state_d = S_SPEC;
          end else begin
            state_d = S_SCAN;
          end
        end
      end

      S_SCAN: begin
`ifdef POSIT_DEC_FAST_SCAN_EN
        // Two slots per edge; either slot may hold the terminator.
        for (int s = 0; s < 2; s++) begin
          if (!fin_t) begin
            if (r_t == R_MAX) begin
              fin_t = 1'b1;
            end else if (sh_t[N-2] == rc_q) begin
              r_t  = r_t + R_ONE;
              sh_t = sh_t << 1;
              if (r_t == R_MAX) fin_t = 1'b1;
            end else begin
              sh_t  = sh_t << 1;
              fin_t = 1'b1;
            end
          end
        end
        sh_d = sh_t;
        r_d  = r_t;
        if (fin_t) state_d = S_DONE;
`else
        // The top bit always belongs to the run; look one bit ahead so the
        // terminator is consumed on the same edge as the last run bit.
        r_d = r_q + R_ONE;
        if ((r_q + R_ONE) == R_MAX) begin
          sh_d    = sh_q << 1;
          state_d = S_DONE;
        end else if (sh_q[N-3] != rc_q) begin
          sh_d    = sh_q << 2;
          state_d = S_DONE;
        end else begin
          sh_d    = sh_q << 1;
        end
`endif
      end

      S_SPEC: begin
        done_d  = 1'b1;
        sign_d  = sgn_q;
        zero_d  = isz_q;
        inf_d   = ~isz_q;
        scale_d = '0;
        frac_d  = '0;
        state_d = S_IDLE;
      end

      S_DONE: begin
        // Exponent bits beyond the LSB were shifted in as zeros.
        done_d  = 1'b1;
        sign_d  = sgn_q;
        zero_d  = 1'b0;
        inf_d   = 1'b0;
        scale_d = {k_w, sh_q[N-2 -: ES]};
        frac_d  = {sh_q[N-2-ES:0], 1'b0};
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = done_q;
  assign sign_o  = sign_q;
  assign zero_o  = zero_q;
  assign inf_o   = inf_q;
  assign scale_o = scale_q;
  assign frac_o  = frac_q;

endmodule
